// File: rtl/load_store_unit.sv
// Load/store unit: turns one load/store request into one or two aligned
// data-memory word transactions and returns a single response pulse.
module load_store_unit #(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AWIDTH-1:0] dmem_addr_o,
    output logic [DWIDTH-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DWIDTH-1:0] dmem_rdata_i,
    output logic              rsp_valid_o,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    // Legal RV32I width/sign codes for each direction.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Access size in bytes from funct3[1:0].
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when the access spills past the end of its first word.
    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

    // Byte enables for beat 0 (hi = 0) or beat 1 (hi = 1).
    function automatic logic [3:0] beat_be(input logic [1:0] off, input logic [1:0] size,
                                           input logic hi);
        logic [7:0] mask;
        case (size)
            2'b00:   mask = 8'h01;
            2'b01:   mask = 8'h03;
            default: mask = 8'h0F;
        endcase
        mask = mask << off;
        return hi ? mask[7:4] : mask[3:0];
    endfunction

    // Store data moved onto its byte lanes, split across two words.
    function automatic logic [DWIDTH-1:0] beat_wdata(input logic [DWIDTH-1:0] wd,
                                                     input logic [1:0] off, input logic hi);
        logic [2*DWIDTH-1:0] w;
        w = {{DWIDTH{1'b0}}, wd} << {off, 3'b000};
        return hi ? w[2*DWIDTH-1:DWIDTH] : w[DWIDTH-1:0];
    endfunction

    // Re-align the two read words and apply sign/zero extension.
    function automatic logic [DWIDTH-1:0] load_result(input logic [2:0] f3, input logic [1:0] off,
                                                      input logic [DWIDTH-1:0] lo,
                                                      input logic [DWIDTH-1:0] hi);
        logic [DWIDTH-1:0] l;
        l = DWIDTH'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'b000:  return {{(DWIDTH-8){l[7]}}, l[7:0]};
            3'b100:  return {{(DWIDTH-8){1'b0}}, l[7:0]};
            3'b001:  return {{(DWIDTH-16){l[15]}}, l[15:0]};
            3'b101:  return {{(DWIDTH-16){1'b0}}, l[15:0]};
            default: return l;
        endcase
    endfunction

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   rdata0_q, rdata0_d;
    logic                req_ready_q, req_ready_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [AWIDTH-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DWIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic [3:0]          dmem_be_q, dmem_be_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_be_d    = dmem_be_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    funct3_d = req_funct3_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    if (!is_legal(req_we_i, req_funct3_i) ||
                        (!SPLIT_EN && crosses_word(req_addr_i[1:0], req_funct3_i[1:0]))) begin
                        state_d     = RESP;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d      = REQ0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = req_we_i;
                        dmem_addr_d  = {req_addr_i[AWIDTH-1:2], 2'b00};
                        dmem_be_d    = beat_be(req_addr_i[1:0], req_funct3_i[1:0], 1'b0);
                        dmem_wdata_d = req_we_i ? beat_wdata(req_wdata_i, req_addr_i[1:0], 1'b0)
                                                : '0;
                    end
                end
            end
            REQ0: begin
                if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    state_d    = WAIT0;
                end
            end
            WAIT0: begin
                if (dmem_rvalid_i) begin
                    rdata0_d = dmem_rdata_i;
                    if (crosses_word(addr_q[1:0], funct3_q[1:0])) begin
                        state_d      = REQ1;
                        dmem_req_d   = 1'b1;
                        dmem_addr_d  = {addr_q[AWIDTH-1:2] + (AWIDTH-2)'(1), 2'b00};
                        dmem_be_d    = beat_be(addr_q[1:0], funct3_q[1:0], 1'b1);
                        dmem_wdata_d = we_q ? beat_wdata(wdata_q, addr_q[1:0], 1'b1) : '0;
                    end else begin
                        state_d     = RESP;
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? '0
                                           : load_result(funct3_q, addr_q[1:0], dmem_rdata_i, '0);
                    end
                end
            end
            REQ1: begin
                if (dmem_gnt_i) begin
                    dmem_req_d = 1'b0;
                    state_d    = WAIT1;
                end
            end
            WAIT1: begin
                if (dmem_rvalid_i) begin
                    state_d     = RESP;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0
                                       : load_result(funct3_q, addr_q[1:0], rdata0_q, dmem_rdata_i);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // Control and output registers reset; request latches simply follow _d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_be_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_be_q    <= dmem_be_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
        we_q     <= we_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
        rdata0_q <= rdata0_d;
    end

    assign req_ready_o  = req_ready_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_wdata_o = dmem_wdata_q;
    assign dmem_be_o    = dmem_be_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_err_o    = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one split-enabled and one split-disabled instance.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_valid_b;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        req_ready, dmem_req, dmem_we, rsp_valid, rsp_err;
    logic [31:0] dmem_addr, dmem_wdata, rsp_rdata;
    logic [3:0]  dmem_be;

    logic        req_ready_b, dmem_req_b, dmem_we_b, rsp_valid_b, rsp_err_b;
    logic [31:0] dmem_addr_b, dmem_wdata_b, rsp_rdata_b;
    logic [3:0]  dmem_be_b;

    int vectors = 0;
    int miscompares = 0;

    // Observations gathered by run_access.
    int          nbeats, npulse, rsp_cyc;
    logic [31:0] b_addr [2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_be   [2];
    logic        b_we   [2];
    logic [31:0] r_data;
    logic        r_err;

    load_store_unit #(.AWIDTH(32), .DWIDTH(32), .SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata), .dmem_be_o(dmem_be), .dmem_gnt_i(dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    load_store_unit #(.AWIDTH(32), .DWIDTH(32), .SPLIT_EN(1'b0)) u_dut_ns (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .dmem_req_o(dmem_req_b), .dmem_we_o(dmem_we_b), .dmem_addr_o(dmem_addr_b),
        .dmem_wdata_o(dmem_wdata_b), .dmem_be_o(dmem_be_b), .dmem_gnt_i(dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
        .rsp_valid_o(rsp_valid_b), .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One request with immediate grant and rvalid one cycle after each grant.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd0,
                              input logic [31:0] rd1);
        logic pending;
        nbeats  = 0;
        npulse  = 0;
        rsp_cyc = -1;
        r_data  = 'x;
        r_err   = 1'bx;
        pending = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        dmem_gnt   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            dmem_rvalid = 1'b0;
            if (pending) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = (nbeats == 1) ? rd0 : rd1;
                pending     = 1'b0;
            end
            if (dmem_req) begin
                if (nbeats < 2) begin
                    b_addr[nbeats]  = dmem_addr;
                    b_wdata[nbeats] = dmem_wdata;
                    b_be[nbeats]    = dmem_be;
                    b_we[nbeats]    = dmem_we;
                end
                nbeats++;
                pending = 1'b1;
            end
            if (rsp_valid) begin
                npulse++;
                if (npulse == 1) begin
                    rsp_cyc = c;
                    r_data  = rsp_rdata;
                    r_err   = rsp_err;
                end
            end
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid_b = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk1("rst_ready", req_ready, 1'b1);
        chk1("rst_dmem_req", dmem_req, 1'b0);
        chk1("rst_dmem_we", dmem_we, 1'b0);
        chk32("rst_dmem_addr", dmem_addr, 32'h0);
        chk32("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk32("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk1("rst_rsp_err", rsp_err, 1'b0);
        chk1("rst_b_ready", req_ready_b, 1'b1);
        chk1("rst_b_req", dmem_req_b | dmem_we_b, 1'b0);
        chk32("rst_b_addr", dmem_addr_b | dmem_wdata_b | {28'h0, dmem_be_b}, 32'h0);

        // Aligned LW
        run_access(1'b0, 3'b010, 32'h0100_0008, 32'h0, 32'hDEAD_BEEF, 32'h0);
        chk32("lw_beats", 32'(nbeats), 32'd1);
        chk32("lw_addr", b_addr[0], 32'h0100_0008);
        chk32("lw_be", {28'h0, b_be[0]}, 32'hF);
        chk1("lw_we", b_we[0], 1'b0);
        chk32("lw_wdata", b_wdata[0], 32'h0);
        chk32("lw_cyc", 32'(rsp_cyc), 32'd3);
        chk32("lw_rdata", r_data, 32'hDEAD_BEEF);
        chk1("lw_err", r_err, 1'b0);
        chk32("lw_pulses", 32'(npulse), 32'd1);
        chk1("lw_ready_after", req_ready, 1'b1);
        chk32("lw_hold", rsp_rdata, 32'hDEAD_BEEF);

        // LB / LBU at byte 3
        run_access(1'b0, 3'b000, 32'h0100_0003, 32'h0, 32'h80FF_FF7F, 32'h0);
        chk32("lb_addr", b_addr[0], 32'h0100_0000);
        chk32("lb_be", {28'h0, b_be[0]}, 32'h8);
        chk32("lb_rdata", r_data, 32'hFFFF_FF80);
        run_access(1'b0, 3'b100, 32'h0100_0003, 32'h0, 32'h80FF_FF7F, 32'h0);
        chk32("lbu_be", {28'h0, b_be[0]}, 32'h8);
        chk32("lbu_rdata", r_data, 32'h0000_0080);

        // Illegal load funct3
        run_access(1'b0, 3'b011, 32'h0100_0000, 32'h0, 32'h1234_5678, 32'h0);
        chk32("ld011_beats", 32'(nbeats), 32'd0);
        chk32("ld011_cyc", 32'(rsp_cyc), 32'd1);
        chk1("ld011_err", r_err, 1'b1);
        chk32("ld011_rdata", r_data, 32'h0);

        // Split LH, sign from upper word
        run_access(1'b0, 3'b001, 32'h0100_0003, 32'h0, 32'hAABB_CCDD, 32'h1122_33F4);
        chk32("lh_split_beats", 32'(nbeats), 32'd2);
        chk32("lh_split_addr1", b_addr[1], 32'h0100_0004);
        chk32("lh_split_be0", {28'h0, b_be[0]}, 32'h8);
        chk32("lh_split_be1", {28'h0, b_be[1]}, 32'h1);
        chk32("lh_split_cyc", 32'(rsp_cyc), 32'd5);
        chk32("lh_split_rdata", r_data, 32'hFFFF_F4AA);

        // SH single beat
        run_access(1'b1, 3'b001, 32'h0100_0001, 32'h0000_ABCD, 32'h1234_5678, 32'h0);
        chk32("sh_beats", 32'(nbeats), 32'd1);
        chk32("sh_addr", b_addr[0], 32'h0100_0000);
        chk32("sh_be", {28'h0, b_be[0]}, 32'h6);
        chk32("sh_wdata", b_wdata[0], 32'h00AB_CD00);
        chk1("sh_we", b_we[0], 1'b1);
        chk32("sh_rdata", r_data, 32'h0);
        chk1("sh_err", r_err, 1'b0);

        // SW split
        run_access(1'b1, 3'b010, 32'h0100_0006, 32'h1122_3344, 32'h0, 32'h0);
        chk32("sw_beats", 32'(nbeats), 32'd2);
        chk32("sw_addr0", b_addr[0], 32'h0100_0004);
        chk32("sw_be0", {28'h0, b_be[0]}, 32'hC);
        chk32("sw_wdata0", b_wdata[0], 32'h3344_0000);
        chk32("sw_addr1", b_addr[1], 32'h0100_0008);
        chk32("sw_be1", {28'h0, b_be[1]}, 32'h3);
        chk32("sw_wdata1", b_wdata[1], 32'h0000_1122);
        chk1("sw_we1", b_we[1], 1'b1);
        chk32("sw_pulses", 32'(npulse), 32'd1);
        chk32("sw_cyc", 32'(rsp_cyc), 32'd5);

        // Illegal store funct3
        run_access(1'b1, 3'b100, 32'h0100_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        chk32("st100_beats", 32'(nbeats), 32'd0);
        chk32("st100_cyc", 32'(rsp_cyc), 32'd1);
        chk1("st100_err", r_err, 1'b1);
        chk32("st100_rdata", r_data, 32'h0);

        // Same misaligned SW on the split-disabled instance
        req_valid_b = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0100_0006; req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid_b = 1'b0;
        chk1("ns_dmem_req_t1", dmem_req_b, 1'b0);
        chk1("ns_rsp_valid_t1", rsp_valid_b, 1'b1);
        chk1("ns_rsp_err", rsp_err_b, 1'b1);
        chk32("ns_rsp_rdata", rsp_rdata_b, 32'h0);
        @(negedge clk);
        chk1("ns_dmem_req_t2", dmem_req_b, 1'b0);
        chk1("ns_rsp_valid_t2", rsp_valid_b, 1'b0);
        chk1("ns_ready_t2", req_ready_b, 1'b1);

        // Split LW at top of memory, delayed grant, reset while in WAIT1
        dmem_gnt = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'hFFFF_FFFE; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk1("wrap_req_hold", dmem_req, 1'b1);
            chk32("wrap_addr0", dmem_addr, 32'hFFFF_FFFC);
            chk32("wrap_be0", {28'h0, dmem_be}, 32'hC);
            if (k == 4) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        chk1("wrap_wait0_req", dmem_req, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk1("wrap_req1", dmem_req, 1'b1);
        chk32("wrap_addr1", dmem_addr, 32'h0000_0000);
        chk32("wrap_be1", {28'h0, dmem_be}, 32'h3);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk1("wrap_wait1_req", dmem_req, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        chk1("wrap_ready_after_rst", req_ready, 1'b1);
        chk1("wrap_req_after_rst", dmem_req, 1'b0);
        chk1("wrap_rsp_after_rst", rsp_valid, 1'b0);
        chk32("wrap_rdata_after_rst", rsp_rdata, 32'h0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        chk1("wrap_late_rvalid_rsp", rsp_valid, 1'b0);
        chk1("wrap_late_rvalid_ready", req_ready, 1'b1);
        @(negedge clk);
        chk1("wrap_idle_rsp", rsp_valid, 1'b0);
        chk1("wrap_idle_req", dmem_req, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage between the ALU and writeback in the pd-series RISC-V core. It takes one load or store request per handshake. The ALU result is the effective address, rs2 data is the store data, and funct3 gives the access width. The block drives a word-aligned data-memory port with byte enables. Misaligned accesses are split into two aligned word transactions, load data is re-assembled and sign- or zero-extended, and the result is returned to writeback as a one-cycle response pulse.

Parameters:
AWIDTH, 32, address width; only 32 is supported.
DWIDTH, 32, data width; only 32 is supported.
SPLIT_EN, 1, 1 = misaligned accesses are split into two beats; 0 = misaligned accesses return an error and never touch memory.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  request valid from execute
req_ready_o  out  1  stage can accept a request
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  RV32I width/sign code
req_addr_i  in  32  effective byte address
req_wdata_i  in  32  store data (rs2)
dmem_req_o  out  1  memory request valid
dmem_we_o  out  1  memory write
dmem_addr_o  out  32  word-aligned address (bits [1:0] = 0)
dmem_wdata_o  out  32  lane-aligned write data
dmem_be_o  out  4  byte enables
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  response/ack for the accepted beat
dmem_rdata_i  in  32  read word, valid with dmem_rvalid_i
rsp_valid_o  out  1  one-cycle completion pulse to writeback
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  illegal funct3 or disallowed misalignment

Behaviour:
- Single clock clk. rst is synchronous and active-high. All state and outputs are registered.
- Reset values: state = IDLE, req_ready_o = 1, and all dmem_* outputs, rsp_valid_o, rsp_rdata_o and rsp_err_o = 0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready_o = 1 only in IDLE.
  - On req_valid_i, the block latches we, funct3, addr and wdata.
  - Size n: funct3[1:0] = 00 gives 1 byte, 01 gives 2, 10 gives 4.
  - Legal loads: funct3 000, 001, 010, 100, 101. Legal stores: funct3 000, 001, 010.
  - Illegal funct3 goes to RESP with err = 1.
  - If o = addr[1:0] and o + n > 4 and SPLIT_EN = 0, go to RESP with err = 1.
  - Otherwise go to REQ0.
- Beat computation:
  - Beat-0 address is addr & ~3. Beat-1 address is beat-0 address + 4, wrapping modulo 2^32.
  - Let W = {32'b0, wdata} << 8*o.
  - Beat 0: be0 = lanes o through min(3, o+n-1); wdata0 = W[31:0].
  - Beat 1 (only when o + n > 4): be1 = lanes 0 through o+n-5; wdata1 = W[63:32].
  - For loads, dmem_wdata_o = 0 but byte enables are still driven.
- REQ0: dmem_req_o is held high and addr/we/be/wdata are held stable until dmem_gnt_i; then go to WAIT0.
- WAIT0: on dmem_rvalid_i, capture rdata0. Go to REQ1 if split, else RESP.
- REQ1 and WAIT1 behave like REQ0 and WAIT0, capturing rdata1, then go to RESP.
- dmem_rvalid_i is only honoured in WAIT0 and WAIT1; it is ignored in every other state. One transaction is outstanding at most.
- Load assembly: L = ({rdata1, rdata0} >> 8*o)[31:0]; rdata1 = 0 when there is no split.
  - LB: sign-extend L[7:0]. LBU: zero-extend L[7:0].
  - LH: sign-extend L[15:0]. LHU: zero-extend L[15:0].
  - LW: L.
- RESP: rsp_valid_o = 1 for exactly one cycle with rsp_rdata_o and rsp_err_o, then go to IDLE.
  - rsp_rdata_o and rsp_err_o hold their values until the next RESP.
  - There is no downstream backpressure.
- Latency with grant in the same cycle and rvalid one cycle later:
  - Accept at cycle t, REQ0 at t+1, WAIT0 at t+2, RESP at t+3.
  - A split access adds 2 cycles.
  - An error response goes to RESP at t+1.
- Reset mid-operation: the next state is IDLE, dmem_req_o drops, and the transaction is abandoned with no rsp_valid_o. Any late dmem_rvalid_i is ignored.
- A req_valid_i presented while req_ready_o = 0 is not accepted; upstream must hold it.

Test Plan:
- Aligned LW at 0x01000008, memory word 0xDEADBEEF, immediate grant -> dmem_addr_o = 0x01000008, dmem_be_o = 1111, rsp_valid_o at t+3, rsp_rdata_o = 0xDEADBEEF.
- LB at 0x01000003 with word 0x80FF_FF7F vs LBU at the same address -> rsp_rdata_o = 0xFFFFFF80 and 0x00000080; be = 1000.
- SH at 0x01000001 with data 0x0000ABCD -> single beat, be = 0110, wdata = 0x00ABCD00, rsp_rdata_o = 0, err = 0.
- SW at 0x01000006 with data 0x11223344, SPLIT_EN = 1 -> beat0 at 0x01000004 with be 1100, wdata 0x33440000; beat1 at 0x01000008 with be 0011, wdata 0x00001122; one rsp_valid_o pulse. Same request with SPLIT_EN = 0 -> no dmem_req_o, rsp_err_o = 1 at t+1.
- Load with funct3 = 011, and store with funct3 = 100 -> no dmem_req_o, rsp_err_o = 1, rsp_rdata_o = 0.
- LW at 0xFFFFFFFE (split) with dmem_gnt_i held low 3 cycles, then rst asserted in WAIT1 -> addresses 0xFFFFFFFC then 0x00000000 (wrap), dmem_req_o stable while ungranted, no rsp_valid_o after reset, req_ready_o = 1 the cycle after reset.
